// File: rtl/fir_frame_ctrl.sv
// fir_frame_ctrl: frame sequencer between a byte-wide UART receiver, a 32-bit
// FIR datapath and a byte-wide UART transmitter.
//   clk, rst (async, active low), enable (level; low returns to IDLE)
//   rx_valid/rx_data   : received byte strobe and data
//   fir_start/fir_din  : FIR launch pulse and assembled sample (held)
//   fir_dout           : FIR result, captured FIR_LAT cycles after launch
//   tx_start/tx_byte   : transmit strobe and byte (held while sending)
//   tx_busy            : transmitter busy
//   busy, frame_done, timeout_err, overrun_err, frame_count : status
module fir_frame_ctrl #(
  parameter int unsigned FIR_LAT    = 7,
  parameter int unsigned RX_GAP_MAX = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        fir_start,
  output logic [31:0] fir_din,
  input  logic [31:0] fir_dout,
  output logic        tx_start,
  output logic [7:0]  tx_byte,
  input  logic        tx_busy,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout_err,
  output logic        overrun_err,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {
    IDLE, RX, FIR_START, FIR_WAIT, TX_START, TX_HOLD, TX_WAIT, DONE
  } state_e;

  localparam logic [7:0]  LAT_LAST = 8'(FIR_LAT - 1);
  localparam logic [31:0] GAP_LAST = 32'(RX_GAP_MAX - 1);

  state_e      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] gap_q, gap_d;
  logic [7:0]  lat_q, lat_d;
  logic [31:0] result_q, result_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] fir_din_q, fir_din_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [15:0] count_q, count_d;
  logic        busy_q, busy_d;
  logic        fir_start_q, fir_start_d;
  logic        tx_start_q, tx_start_d;
  logic        frame_done_q, frame_done_d;
  logic        timeout_q, timeout_d;
  logic        overrun_q, overrun_d;

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    pick_byte = w[31:24];
      2'd1:    pick_byte = w[23:16];
      2'd2:    pick_byte = w[15:8];
      default: pick_byte = w[7:0];
    endcase
  endfunction

  // Pulse outputs are computed from the transition being taken, so each is
  // registered yet lines up with the state it belongs to.
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    byte_cnt_d   = byte_cnt_q;
    gap_d        = gap_q;
    lat_d        = lat_q;
    result_d     = result_q;
    idx_d        = idx_q;
    fir_din_d    = fir_din_q;
    tx_byte_d    = tx_byte_q;
    count_d      = count_q;
    busy_d       = busy_q;
    fir_start_d  = 1'b0;
    tx_start_d   = 1'b0;
    frame_done_d = 1'b0;
    timeout_d    = 1'b0;
    overrun_d    = rx_valid && (state_q != RX);

    if (!enable) begin
      state_d    = IDLE;
      byte_cnt_d = '0;
      gap_d      = '0;
      lat_d      = '0;
      idx_d      = '0;
      busy_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = RX;

        RX: begin
          if (rx_valid) begin
            word_d = {word_q[23:0], rx_data};
            gap_d  = '0;
            busy_d = 1'b1;
            if (byte_cnt_q == 2'd3) begin
              fir_din_d   = {word_q[23:0], rx_data};
              byte_cnt_d  = '0;
              fir_start_d = 1'b1;
              state_d     = FIR_START;
            end else begin
              byte_cnt_d = byte_cnt_q + 2'd1;
            end
          end else if (byte_cnt_q != 2'd0) begin
            if (gap_q == GAP_LAST) begin
              byte_cnt_d = '0;
              gap_d      = '0;
              busy_d     = 1'b0;
              timeout_d  = 1'b1;
            end else begin
              gap_d = gap_q + 32'd1;
            end
          end
        end

        FIR_START: begin
          lat_d   = '0;
          state_d = FIR_WAIT;
        end

        FIR_WAIT: begin
          if (lat_q == LAT_LAST) begin
            result_d   = fir_dout;
            idx_d      = '0;
            tx_byte_d  = pick_byte(fir_dout, 2'd0);
            tx_start_d = 1'b1;
            state_d    = TX_START;
          end else begin
            lat_d = lat_q + 8'd1;
          end
        end

        TX_START: state_d = TX_HOLD;

        // Gives the transmitter one cycle to raise tx_busy.
        TX_HOLD: state_d = TX_WAIT;

        TX_WAIT: begin
          if (!tx_busy) begin
            if (idx_q == 2'd3) begin
              frame_done_d = 1'b1;
              count_d      = count_q + 16'd1;
              state_d      = DONE;
            end else begin
              idx_d      = idx_q + 2'd1;
              tx_byte_d  = pick_byte(result_q, idx_q + 2'd1);
              tx_start_d = 1'b1;
              state_d    = TX_START;
            end
          end
        end

        DONE: begin
          busy_d  = 1'b0;
          state_d = RX;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      word_q       <= '0;
      byte_cnt_q   <= '0;
      gap_q        <= '0;
      lat_q        <= '0;
      result_q     <= '0;
      idx_q        <= '0;
      fir_din_q    <= '0;
      tx_byte_q    <= '0;
      count_q      <= '0;
      busy_q       <= 1'b0;
      fir_start_q  <= 1'b0;
      tx_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      byte_cnt_q   <= byte_cnt_d;
      gap_q        <= gap_d;
      lat_q        <= lat_d;
      result_q     <= result_d;
      idx_q        <= idx_d;
      fir_din_q    <= fir_din_d;
      tx_byte_q    <= tx_byte_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
      fir_start_q  <= fir_start_d;
      tx_start_q   <= tx_start_d;
      frame_done_q <= frame_done_d;
      timeout_q    <= timeout_d;
      overrun_q    <= overrun_d;
    end
  end

  assign fir_start   = fir_start_q;
  assign fir_din     = fir_din_q;
  assign tx_start    = tx_start_q;
  assign tx_byte     = tx_byte_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign timeout_err = timeout_q;
  assign overrun_err = overrun_q;
  assign frame_count = count_q;

endmodule

// File: doc/fir_frame_ctrl.md
Name: fir_frame_ctrl

Overview:
Frame sequencer between the byte-wide UART receiver, the 32-bit FIR filter datapath and the byte-wide UART transmitter. It assembles four received bytes into one 32-bit IEEE-754 sample, launches the FIR, and waits a fixed latency. It then captures the FIR output and serializes it as four bytes to the transmitter. It also provides an inter-byte timeout, overrun detection and a frame counter.

Parameters:
FIR_LAT, 7, cycles from the fir_start pulse to a valid fir_dout; legal range 1..255.
RX_GAP_MAX, 50000, idle cycles allowed between bytes of a partial frame before it is discarded; legal range 1..2^32-1.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
enable  in  1  level enable; low forces synchronous return to IDLE
rx_valid  in  1  one-cycle pulse: rx_data holds a new byte
rx_data  in  8  received byte
fir_start  out  1  one-cycle pulse launching the FIR on fir_din
fir_din  out  32  sample to the FIR; held stable after each frame is assembled
fir_dout  in  32  FIR result
tx_start  out  1  one-cycle pulse: transmit tx_byte
tx_byte  out  8  byte to the transmitter; held stable while sending
tx_busy  in  1  transmitter busy
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after the 4th output byte completes
timeout_err  out  1  one-cycle pulse: partial frame discarded
overrun_err  out  1  one-cycle pulse: byte dropped while not in RX
frame_count  out  16  completed frames; wraps 0xFFFF->0x0000

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0, including fir_din, tx_byte and frame_count. Internal byte_cnt, gap counter, latency counter, result and tx index are cleared.
- enable=0 in any state: next edge returns to IDLE and clears byte_cnt, counters, busy, tx_start and fir_start. frame_count and fir_din are retained.
- States: IDLE, RX, FIR_START, FIR_WAIT, TX_START, TX_HOLD, TX_WAIT, DONE.
- IDLE: go to RX when enable=1.
- RX, on rx_valid:
  - word <= {word[23:0], rx_data}; the first byte lands in [31:24].
  - byte_cnt++ and gap counter cleared.
  - busy=1 from the edge that accepts the first byte.
  - When the 4th byte is accepted (edge T): fir_din <= assembled word, byte_cnt<=0, next state FIR_START.
- RX timeout:
  - With byte_cnt>0 and no rx_valid, the gap counter increments each cycle.
  - When it reaches RX_GAP_MAX: byte_cnt<=0, gap<=0, busy<=0, timeout_err pulses one cycle, stay in RX.
  - rx_valid in the same cycle as the timeout condition: the byte is accepted and no timeout occurs.
  - The gap counter does not run when byte_cnt=0.
- FIR_START: fir_start=1 for exactly that one cycle (the cycle after T); latency counter cleared; then FIR_WAIT.
- FIR_WAIT:
  - Latency counter increments each cycle.
  - When the counter equals FIR_LAT-1, the edge captures result <= fir_dout. That edge is exactly FIR_LAT cycles after the fir_start edge.
  - tx index <= 0; go to TX_START.
- TX_START: tx_byte = result byte[index] (index 0 = [31:24], 3 = [7:0]); tx_start=1 for this cycle; go to TX_HOLD.
- TX_HOLD: one cycle; tx_busy is ignored. Go to TX_WAIT.
- TX_WAIT:
  - Wait for tx_busy=0.
  - If index=3, go to DONE; otherwise index++ and go to TX_START.
- DONE: frame_done=1 for one cycle; frame_count++ (wraps); busy<=0; go to RX.
- rx_valid in FIR_START, FIR_WAIT, TX_*, DONE or IDLE: the byte is dropped and overrun_err pulses the next cycle. The frame in progress is unaffected.
- Output timing: every pulse output is registered and never high for two consecutive cycles from one event.
- Latency: first tx_start is high in cycle T+2+FIR_LAT, counted from the 4th-byte acceptance edge T.

Test Plan:
1. Reset with enable=1: send 0x3F,0x80,0x00,0x00. Required: fir_din=0x3F800000; fir_start pulses once, 1 cycle after the 4th byte; capture occurs FIR_LAT=7 cycles later. With fir_dout stubbed to 0x40490FDB, tx bytes are 0x40,0x49,0x0F,0xDB in order, then frame_done pulses and frame_count=1.
2. Send 2 bytes, then idle RX_GAP_MAX=100 cycles. Required: timeout_err pulses exactly once at cycle 100 and busy drops. A following 4-byte frame 0x11,0x22,0x33,0x44 yields fir_din=0x11223344.
3. Inject rx_valid while in FIR_WAIT and again during TX_WAIT. Required: two overrun_err pulses. The output bytes still match the captured result, and frame_count increments by 1.
4. Stub tx_busy high for 500 cycles per byte. Required: exactly 4 tx_start pulses, each only after tx_busy has returned to 0; tx_byte is stable throughout each byte.
5. Deassert rst mid-TX (after byte 2). Required: all outputs 0 immediately (async) and frame_count=0. Drop enable mid-FIR_WAIT instead: next edge gives IDLE, busy=0, no tx_start, and frame_count is unchanged.
6. Preload via 65535 frames (or force the counter to 0xFFFF), then complete one frame. Required: frame_count=0x0000 and frame_done pulses.
